// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions, TX/RX state encodings and the baud divisor helper.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CONTROL = 2'd3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_BUSY     = 4;
    localparam int ST_OVERRUN     = 5;
    localparam int ST_FRAME_ERR   = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Rounded clock cycles per bit period.
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push while full is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags and an
// optional registered interrupt (enabled by defining UART_IRQ_EN).
module mmio_uart #(
    parameter int          CLK_FREQ   = 150000000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h40000020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    import uart_pkg::*;

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    logic [1:0]  reg_sel;
    logic        sts_wr;
    logic        tx_push, tx_pop, tx_full, tx_empty, tx_busy;
    logic [7:0]  tx_dout;
    logic [AW:0] tx_count;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic [AW:0] rx_count;
    logic [7:0]  rx_count8;
    logic        overrun, frame_err;
    logic [1:0]  ctrl;
    logic [31:0] status;

    assign hit     = (address >= BASE_ADDR) && (address <= BASE_ADDR + 32'd15);
    assign reg_sel = address[3:2];
    // Fullness is sampled before the edge, so a concurrent TX pop cannot rescue a write.
    assign tx_push = hit & write & (reg_sel == REG_TXDATA) & ~tx_full;
    assign rx_pop  = hit & read & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign sts_wr  = hit & write & (reg_sel == REG_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(write_data[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_pop       = 1'b0;
        tx           = 1'b1;
        if (tx_state != TX_IDLE) tx_cnt_nxt = tx_tick ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop       = 1'b1;
                tx_shift_nxt = tx_dout;
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_START;
            end
            TX_START: begin
                tx = 1'b0;
                if (tx_tick) begin
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                tx = tx_shift[0];
                if (tx_tick) begin
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_bit_nxt   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: if (tx_tick) begin
                // Chain straight into the next start bit so frames stay contiguous.
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = tx_dout;
                    tx_state_nxt = TX_START;
                end else begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic [1:0]    rx_sync;
    logic          rx_s, rx_prev, rx_done, rx_ferr;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_ferr      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_s) rx_state_nxt = RX_START;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_nxt   = '0;
                rx_bit_nxt   = '0;
                rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_nxt   = '0;
                rx_shift_nxt = {rx_s, rx_shift[7:1]};
                rx_bit_nxt   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            end
            RX_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = RX_IDLE;
                rx_done      = rx_s;
                rx_ferr      = ~rx_s;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_done), .pop(rx_pop), .din(rx_shift),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // A new error in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (sts_wr && write_data[ST_OVERRUN])   overrun   <= 1'b0;
            if (sts_wr && write_data[ST_FRAME_ERR]) frame_err <= 1'b0;
            if (rx_done && rx_full && !rx_pop)      overrun   <= 1'b1;
            if (rx_ferr)                            frame_err <= 1'b1;
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= 2'b00;
            irq  <= 1'b0;
        end else begin
            if (hit && write && reg_sel == REG_CONTROL) ctrl <= write_data[1:0];
            irq <= (~rx_empty & ctrl[0]) | (tx_empty & ~tx_busy & ctrl[1]);
        end
    end
`else
    assign ctrl = 2'b00;
    assign irq  = 1'b0;
`endif

    // ---------------- register read ----------------
    always_comb begin
        rx_count8 = (int'(rx_count) > 255) ? 8'hff : 8'(rx_count);
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_NONEMPTY] = ~rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_BUSY]     = tx_busy;
        status[ST_OVERRUN]     = overrun;
        status[ST_FRAME_ERR]   = frame_err;
        status[15:8]           = rx_count8;
    end

    always_comb begin
        read_data = '0;
        if (hit && read) begin
            case (reg_sel)
                REG_RXDATA:  read_data = {24'b0, rx_empty ? 8'h00 : rx_dout};
                REG_STATUS:  read_data = status;
                REG_CONTROL: read_data = {30'b0, ctrl};
                default:     read_data = '0;
            endcase
        end
    end

    logic unused;
    assign unused = ^{address[1:0], write_data[31:8], tx_count};

endmodule

// File: tb/tb_mmio_uart.sv
// Randomized self-checking bench for mmio_uart: line-level TX decoding,
// RX driver with a queue-based FIFO/flag model, and reset/irq corner cases.
module tb_mmio_uart;

    localparam int          CLK_FREQ   = 1000000;
    localparam int          BAUD_RATE  = 100000;
    localparam int          FIFO_DEPTH = 4;
    localparam int          DIV        = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam logic [31:0] BASE  = 32'h40000020;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_RX  = BASE + 32'd4;
    localparam logic [31:0] A_ST  = BASE + 32'd8;
    localparam logic [31:0] A_CTL = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset, read, write, rx, tx, irq, hit;
    logic [31:0] address, write_data, read_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    logic       ov_m, fe_m;
    logic [7:0] bb [6];
    logic [31:0] d;

    mmio_uart #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(read_data), .hit(hit), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        address = a; write_data = v; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        address = a; read = 1'b1;
        #1 v = read_data;
        @(negedge clk);
        read = 1'b0;
    endtask

    // Ideal 8N1 line level k cycles into a frame carrying b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int idx;
        idx = k / DIV;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s     = '0;
        s[1]  = 1'b1;
        s[2]  = (rx_q.size() != 0);
        s[3]  = (rx_q.size() == FIFO_DEPTH);
        s[5]  = ov_m;
        s[6]  = fe_m;
        s[15:8] = 8'(rx_q.size());
        return s;
    endfunction

    task automatic status_check(input string tag);
        logic [31:0] v;
        bus_read(A_ST, v);
        chk(tag, v, exp_status());
    endtask

    task automatic rx_read_check(input string tag);
        logic [31:0] v;
        logic [7:0]  e;
        bus_read(A_RX, v);
        e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        chk(tag, v, {24'b0, e});
    endtask

    task automatic rx_drive(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rx_drive(b, stop);
        if (!stop) fe_m = 1'b1;
        else if (rx_q.size() < FIFO_DEPTH) rx_q.push_back(b);
        else ov_m = 1'b1;
    endtask

    task automatic tx_single(input logic [7:0] b);
        int n, bad;
        logic busy_ok;
        logic [31:0] st;
        bus_write(A_TX, {24'b0, b});
        n = 0;
        while (tx !== 1'b0 && n < 5) begin @(negedge clk); n++; end
        chk("tx_start", tx, 1'b0);
        bad = 0; busy_ok = 1'b1;
        for (int k = 0; k < 10 * DIV; k++) begin
            if (tx !== exp_line(b, k)) bad++;
            bus_read(A_ST, st);
            if (st[4] !== 1'b1) busy_ok = 1'b0;
        end
        chk($sformatf("tx_wave_%02h", b), bad, 0);
        chk("tx_busy_frame", busy_ok, 1'b1);
        bus_read(A_ST, st);
        chk("tx_done_st", st[4:0], 5'b00010);
        chk("tx_idle", tx, 1'b1);
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; rx = 1'b1;
        address = '0; write_data = '0; ov_m = 1'b0; fe_m = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx", tx, 1'b1);
        chk("rst_irq", irq, 1'b0);
        chk("rst_rdata", read_data, 32'h0);
        status_check("rst_status");
        bus_read(A_CTL, d);
        chk("rst_ctrl", d, 32'h0);

        // address window
        address = BASE + 32'd15; #1 chk("hit_top", hit, 1'b1);
        address = BASE + 32'd16; #1 chk("hit_above", hit, 1'b0);
        address = BASE - 32'd1;  #1 chk("hit_below", hit, 1'b0);
        @(negedge clk);
        bus_write(BASE + 32'd16, 32'h5A);
        repeat (5) @(negedge clk);
        chk("nohit_tx", tx, 1'b1);
        bus_read(BASE + 32'd24, d);
        chk("nohit_rd", d, 32'h0);
        status_check("nohit_status");

        // single TX frames
        tx_single(8'h55);
        tx_single(8'($urandom));

        // back-to-back TX with one write beyond capacity
        for (int i = 0; i < 6; i++) bb[i] = 8'($urandom);
        fork
            begin
                logic [31:0] st;
                for (int i = 0; i < 6; i++) bus_write(A_TX, {24'b0, bb[i]});
                bus_read(A_ST, st);
                chk("bb_tx_full", st[0], 1'b1);
            end
            begin
                int n, bad;
                n = 0;
                while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
                chk("bb_start", tx, 1'b0);
                for (int f = 0; f < FIFO_DEPTH + 1; f++) begin
                    bad = 0;
                    for (int k = 0; k < 10 * DIV; k++) begin
                        if (tx !== exp_line(bb[f], k)) bad++;
                        @(negedge clk);
                    end
                    chk($sformatf("bb_frame%0d", f), bad, 0);
                end
            end
        join
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 2 * DIV; k++) begin
                if (tx !== 1'b1) bad++;
                @(negedge clk);
            end
            chk("bb_dropped", bad, 0);
        end
        status_check("bb_end_status");

        // RX single byte
        rx_send(8'hA3, 1'b1);
        status_check("rx1_status");
        rx_read_check("rx1_data");
        rx_read_check("rx1_empty_read");
        status_check("rx1_status_after");

        // RX overrun
        for (int i = 0; i < FIFO_DEPTH + 1; i++) rx_send(8'($urandom), 1'b1);
        status_check("ov_status");
        bus_write(A_ST, 32'h20);
        ov_m = 1'b0;
        status_check("ov_cleared");
        for (int i = 0; i < FIFO_DEPTH; i++) rx_read_check($sformatf("ov_data%0d", i));
        status_check("ov_drained");

        // glitch and framing error
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        status_check("glitch");
        rx_send(8'($urandom), 1'b0);
        status_check("frame_err");
        bus_write(A_ST, 32'h40);
        fe_m = 1'b0;
        status_check("frame_err_clr");

        // random receive/read interleaving
        for (int i = 0; i < 8; i++) begin
            rx_send(8'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) rx_read_check($sformatf("mix_rd%0d", i));
            status_check($sformatf("mix_st%0d", i));
        end
        while (rx_q.size() != 0) rx_read_check("mix_drain");
        bus_write(A_ST, 32'h60);
        ov_m = 1'b0; fe_m = 1'b0;
        status_check("mix_end");

        // reset in the middle of a TX frame (bit 4)
        bus_write(A_TX, {24'b0, 8'($urandom)});
        begin
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 5) begin @(negedge clk); n++; end
        end
        repeat (5 * DIV + DIV / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1'b1);
        reset = 1'b0;
        chk("rst_mid_irq", irq, 1'b0);
        status_check("rst_mid_status");

        // reset in the middle of an RX frame; the remainder must not form a byte
        fork
            rx_drive(8'hF0, 1'b1);
            begin
                repeat (47) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (2 * DIV) @(negedge clk);
        status_check("rst_mid_rx");
        rx_send(8'($urandom), 1'b1);
        rx_read_check("post_rst_rx");

`ifdef UART_IRQ_EN
        bus_write(A_CTL, 32'h1);
        bus_read(A_CTL, d);
        chk("ctrl_rd", d, 32'h1);
        chk("irq_idle", irq, 1'b0);
        begin
            logic [7:0] b;
            logic found, irq0, irq1;
            b = 8'($urandom);
            found = 1'b0; irq0 = 1'bx; irq1 = 1'bx;
            fork
                rx_drive(b, 1'b1);
                begin
                    address = A_ST; read = 1'b1;
                    for (int n = 0; n < 200 && !found; n++) begin
                        @(negedge clk); #1;
                        if (read_data[2]) begin
                            found = 1'b1; irq0 = irq;
                            @(negedge clk);
                            irq1 = irq;
                        end
                    end
                    read = 1'b0;
                end
            join
            rx_q.push_back(b);
            chk("irq_push_seen", found, 1'b1);
            chk("irq_same_cycle", irq0, 1'b0);
            chk("irq_one_later", irq1, 1'b1);
        end
        rx_read_check("irq_pop");
        @(negedge clk);
        chk("irq_after_pop", irq, 1'b0);
        bus_write(A_CTL, 32'h2);
        @(negedge clk);
        chk("irq_tx_empty", irq, 1'b1);
        bus_write(A_CTL, 32'h0);
        @(negedge clk);
        chk("irq_off", irq, 1'b0);
`else
        bus_write(A_CTL, 32'h3);
        bus_read(A_CTL, d);
        chk("ctrl_disabled", d, 32'h0);
        rx_send(8'($urandom), 1'b1);
        chk("irq_disabled", irq, 1'b0);
        rx_read_check("noirq_pop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
